// File: rtl/dma_periph_pkg.sv
// Shared constants for the DMA peripheral responder:
// Avalon address map, CTRL/STATUS field positions and handshake FSM states.
package dma_periph_pkg;

   localparam int ADDR_DATA   = 0;
   localparam int ADDR_STATUS = 1;
   localparam int ADDR_CTRL   = 2;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_DIR       = 1;
   localparam int CTRL_BURST_LSB = 8;
   localparam int CTRL_BURST_W   = 8;

   localparam int STAT_RX_LSB = 0;
   localparam int STAT_TX_LSB = 8;
   localparam int STAT_BUSY   = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER
   } fsm_e;

   // Burst of 0 means 1; anything above the FIFO depth can never be
   // satisfied, so it is clamped to the depth.
   function automatic logic [7:0] eff_burst(
      input logic [7:0] b,
      input int         depth
   );
      if (b == 8'd0) return 8'd1;
      if (int'(b) > depth) return 8'(depth);
      return b;
   endfunction

endpackage

// File: rtl/dma_periph_amm_slave_if.sv
// Avalon-MM bus between the DMA engine (master) and a peripheral responder.
// Signals: address, read, write, writedata, readdata, readdatavalid, waitrequest.
interface dma_periph_amm_slave_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 64
);

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;
   logic              waitrequest;

   modport master (
      output address, read, write, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );

endinterface

// File: rtl/dma_periph_fifo.sv
// Synchronous show-ahead FIFO with level output.
// Ports: clk_i, rst_n_i, push_i/data_i, pop_i/data_o, full_o, empty_o, level_o.
module dma_periph_fifo #(
   parameter  int DATA_W     = 64,
   parameter  int FIFO_DEPTH = 16,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int LW         = AW + 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [LW-1:0]     level_o
);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(FIFO_DEPTH));
   assign level_o = level_q;

   // Push at full needs a matching pop; pop at empty only passes the
   // word being pushed straight through. Either way the level holds.
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & (~empty_o | push_i);

   assign data_o = empty_o ? data_i : mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dma_periph_amm_slave.sv
// Peripheral responder for a DMA channel: RX/TX FIFOs behind an Avalon-MM slave
// plus request/acknowledge burst handshake. Ports: clk_i, rst_n_i, amm (slave),
// request_o, acknowledge_i, src_* (producer into RX), snk_* (TX to consumer).
module dma_periph_amm_slave
   import dma_periph_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   dma_periph_amm_slave_if.slave amm,
   output logic                 request_o,
   input  logic                 acknowledge_i,
   input  logic                 src_valid_i,
   input  logic [DATA_W-1:0]    src_data_i,
   output logic                 src_ready_o,
   output logic                 snk_valid_o,
   output logic [DATA_W-1:0]    snk_data_o,
   input  logic                 snk_ready_i
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic              is_data, is_stat, is_ctrl;
   logic              rd_req, stall, rd_acc, wr_acc;
   logic              rx_push, rx_pop, tx_push, tx_pop;
   logic              rx_full, rx_empty, tx_full, tx_empty;
   logic [LW-1:0]     rx_level, tx_level;
   logic [DATA_W-1:0] rx_dout, tx_dout;
   logic [DATA_W-1:0] rdata_d, rdata_q;
   logic              rvalid_q;

   logic                    en_q, dir_q;
   logic [CTRL_BURST_W-1:0] burst_q;

   fsm_e       state_q;
   logic       req_q, xdir_q;
   logic [7:0] cnt_q;
   logic [7:0] burst_eff, rx_lvl8, tx_lvl8, tx_free8;
   logic       burst_rdy, counted;

   assign is_data = (amm.address == ADDR_W'(ADDR_DATA));
   assign is_stat = (amm.address == ADDR_W'(ADDR_STATUS));
   assign is_ctrl = (amm.address == ADDR_W'(ADDR_CTRL));

   // A read alongside a write is dropped; the write wins.
   assign rd_req = amm.read & ~amm.write;
   assign stall  = ~rst_n_i
                 | (rd_req & is_data & rx_empty)
                 | (amm.write & is_data & tx_full);
   assign rd_acc = rd_req & ~stall;
   assign wr_acc = amm.write & ~stall;

   assign amm.waitrequest   = stall;
   assign amm.readdata      = rdata_q;
   assign amm.readdatavalid = rvalid_q;

   assign rx_pop  = rd_acc & is_data;
   assign tx_push = wr_acc & is_data;

   // A DMA pop frees the slot this cycle, so a full RX still takes a word.
   assign src_ready_o = ~rx_full | rx_pop;
   assign rx_push     = src_valid_i & src_ready_o;
   assign tx_pop      = snk_ready_i & ~tx_empty;
   assign snk_valid_o = ~tx_empty;
   assign snk_data_o  = tx_dout;

   dma_periph_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (rx_push),
      .data_i  (src_data_i),
      .pop_i   (rx_pop),
      .data_o  (rx_dout),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .level_o (rx_level)
   );

   dma_periph_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (tx_push),
      .data_i  (amm.writedata),
      .pop_i   (tx_pop),
      .data_o  (tx_dout),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .level_o (tx_level)
   );

   assign rx_lvl8   = 8'(rx_level);
   assign tx_lvl8   = 8'(tx_level);
   assign tx_free8  = 8'(LW'(FIFO_DEPTH) - tx_level);
   assign burst_eff = eff_burst(burst_q, FIFO_DEPTH);
   assign burst_rdy = dir_q ? (tx_free8 >= burst_eff)
                            : (rx_lvl8 >= burst_eff);
   assign counted   = xdir_q ? tx_push : rx_pop;

   always_comb begin
      rdata_d = '0;
      unique case (1'b1)
         is_data: rdata_d = rx_dout;
         is_stat: begin
            rdata_d[STAT_RX_LSB +: 8] = rx_lvl8;
            rdata_d[STAT_TX_LSB +: 8] = tx_lvl8;
            rdata_d[STAT_BUSY]        = (state_q != ST_IDLE);
         end
         is_ctrl: begin
            rdata_d[CTRL_EN]                            = en_q;
            rdata_d[CTRL_DIR]                           = dir_q;
            rdata_d[CTRL_BURST_LSB +: CTRL_BURST_W]     = burst_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         en_q     <= 1'b0;
         dir_q    <= 1'b0;
         burst_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_acc;
         if (rd_acc) rdata_q <= rdata_d;
         if (wr_acc && is_ctrl) begin
            en_q    <= amm.writedata[CTRL_EN];
            dir_q   <= amm.writedata[CTRL_DIR];
            burst_q <= amm.writedata[CTRL_BURST_LSB +: CTRL_BURST_W];
         end
      end
   end

   // Direction and burst are snapshotted when the request is raised, so
   // CTRL edits during REQ/XFER only affect the next burst.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         xdir_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (en_q && burst_rdy) begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
                  xdir_q  <= dir_q;
                  cnt_q   <= burst_eff;
               end
            end
            ST_REQ: begin
               if (acknowledge_i) begin
                  state_q <= ST_XFER;
                  req_q   <= 1'b0;
               end else if (!en_q) begin
                  state_q <= ST_IDLE;
                  req_q   <= 1'b0;
               end
            end
            ST_XFER: begin
               if (counted) begin
                  if (cnt_q == 8'd1) state_q <= ST_IDLE;
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign request_o = req_q;

endmodule

// File: tb/tb_dma_periph_amm_slave.sv
// Self-checking bench for dma_periph_amm_slave: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_dma_periph_amm_slave;

   localparam int DATA_W     = 64;
   localparam int FIFO_DEPTH = 16;
   localparam int ADDR_W     = 4;

   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_XFER = 2;

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic              request_o;
   logic              acknowledge_i;
   logic              src_valid_i;
   logic [DATA_W-1:0] src_data_i;
   logic              src_ready_o;
   logic              snk_valid_o;
   logic [DATA_W-1:0] snk_data_o;
   logic              snk_ready_i;

   dma_periph_amm_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) amm ();

   dma_periph_amm_slave #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .amm           (amm),
      .request_o     (request_o),
      .acknowledge_i (acknowledge_i),
      .src_valid_i   (src_valid_i),
      .src_data_i    (src_data_i),
      .src_ready_o   (src_ready_o),
      .snk_valid_o   (snk_valid_o),
      .snk_data_o    (snk_data_o),
      .snk_ready_i   (snk_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Reference model: two queues, CTRL fields and the handshake phase.
   logic [DATA_W-1:0] rxq[$];
   logic [DATA_W-1:0] txq[$];
   bit                m_en, m_dir, m_ldir;
   int                m_burst, m_phase, m_left;
   bit                m_req, m_rv;
   logic [63:0]       m_rd;

   function automatic int eff(input int b);
      if (b == 0) return 1;
      if (b > FIFO_DEPTH) return FIFO_DEPTH;
      return b;
   endfunction

   task automatic model_reset();
      rxq.delete();
      txq.delete();
      m_en = 0; m_dir = 0; m_ldir = 0;
      m_burst = 0; m_phase = P_IDLE; m_left = 0;
      m_req = 0; m_rv = 0; m_rd = '0;
   endtask

   function automatic bit exp_wait();
      int a = int'(amm.address);
      bit rd = amm.read && !amm.write;
      return (rd && a == 0 && rxq.size() == 0) ||
             (amm.write && a == 0 && txq.size() == FIFO_DEPTH);
   endfunction

   function automatic bit exp_src_ready(input bit wt);
      bit pop = amm.read && !amm.write && !wt && int'(amm.address) == 0;
      return (rxq.size() < FIFO_DEPTH) || pop;
   endfunction

   task automatic model_step(input bit wt);
      int          a = int'(amm.address);
      bit          rd_acc = amm.read && !amm.write && !wt;
      bit          wr_acc = amm.write && !wt;
      bit          rxpop = rd_acc && a == 0;
      bit          txpush = wr_acc && a == 0;
      bit          rxpush = src_valid_i && exp_src_ready(wt);
      bit          txpop = snk_ready_i && txq.size() > 0;
      bit          hit;
      logic [63:0] v;
      v = '0;
      if (rd_acc) begin
         if (a == 0) v = rxq[0];
         else if (a == 1) begin
            v[7:0]  = 8'(rxq.size());
            v[15:8] = 8'(txq.size());
            v[16]   = (m_phase != P_IDLE);
         end else if (a == 2) begin
            v[0]    = m_en;
            v[1]    = m_dir;
            v[15:8] = 8'(m_burst);
         end
         m_rd = v;
      end
      m_rv = rd_acc;
      hit = (m_phase == P_XFER) && (m_ldir ? txpush : rxpop);
      if (m_phase == P_IDLE) begin
         if (m_en && (m_dir ? (FIFO_DEPTH - txq.size() >= eff(m_burst))
                            : (rxq.size() >= eff(m_burst)))) begin
            m_phase = P_REQ;
            m_left  = eff(m_burst);
            m_ldir  = m_dir;
         end
      end else if (m_phase == P_REQ) begin
         if (acknowledge_i) m_phase = P_XFER;
         else if (!m_en) m_phase = P_IDLE;
      end else if (hit) begin
         m_left--;
         if (m_left == 0) m_phase = P_IDLE;
      end
      m_req = (m_phase == P_REQ);
      if (rxpop) void'(rxq.pop_front());
      if (rxpush) rxq.push_back(src_data_i);
      if (txpop) void'(txq.pop_front());
      if (txpush) txq.push_back(amm.writedata);
      if (wr_acc && a == 2) begin
         m_en    = amm.writedata[0];
         m_dir   = amm.writedata[1];
         m_burst = int'(amm.writedata[15:8]);
      end
   endtask

   // One clock: compare outputs mid-cycle, advance the model, return
   // just after the rising edge so the caller can change inputs.
   task automatic cycle(output bit acc);
      bit wt;
      @(negedge clk_i);
      wt  = exp_wait();
      acc = (amm.read || amm.write) && !wt;
      chk("waitrequest", 64'(amm.waitrequest), 64'(wt));
      chk("src_ready", 64'(src_ready_o), 64'(exp_src_ready(wt)));
      chk("snk_valid", 64'(snk_valid_o), 64'(txq.size() > 0));
      if (txq.size() > 0) chk("snk_data", snk_data_o, txq[0]);
      chk("request", 64'(request_o), 64'(m_req));
      chk("rvalid", 64'(amm.readdatavalid), 64'(m_rv));
      if (m_rv) chk("rdata", amm.readdata, m_rd);
      model_step(wt);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_in();
      amm.address   = '0;
      amm.read      = 1'b0;
      amm.write     = 1'b0;
      amm.writedata = '0;
      acknowledge_i = 1'b0;
      src_valid_i   = 1'b0;
      src_data_i    = '0;
      snk_ready_i   = 1'b0;
   endtask

   task automatic bus(input bit wr, input int addr, input logic [63:0] d);
      bit acc = 0;
      amm.address   = ADDR_W'(addr);
      amm.read      = !wr;
      amm.write     = wr;
      amm.writedata = d;
      for (int i = 0; i < 64 && !acc; i++) cycle(acc);
      if (!acc) chk("bus_timeout", 64'(acc), 64'd1);
      amm.read  = 1'b0;
      amm.write = 1'b0;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle(a);
   endtask

   task automatic rnd_cycle();
      bit          a;
      int          p = int'($urandom_range(0, 19));
      int          op = int'($urandom_range(0, 19));
      logic [63:0] d = {$urandom, $urandom};
      if (p < 10) amm.address = '0;
      else if (p < 14) amm.address = ADDR_W'(1);
      else if (p < 17) amm.address = ADDR_W'(2);
      else amm.address = ADDR_W'($urandom_range(3, 15));
      amm.read  = (op < 7) || (op == 19);
      amm.write = (op >= 7 && op < 13) || (op == 19);
      if (amm.address == ADDR_W'(2)) begin
         d[0]    = ($urandom_range(0, 3) != 0);
         d[15:8] = 8'($urandom_range(0, 20));
      end
      amm.writedata = d;
      acknowledge_i = ($urandom_range(0, 3) == 0);
      src_valid_i   = $urandom_range(0, 1) == 1;
      src_data_i    = {$urandom, $urandom};
      snk_ready_i   = ($urandom_range(0, 2) == 0);
      cycle(a);
   endtask

   initial begin
      bit a;
      idle_in();
      model_reset();
      #12;
      chk("rst_request", 64'(request_o), 64'd0);
      chk("rst_rvalid", 64'(amm.readdatavalid), 64'd0);
      chk("rst_rdata", amm.readdata, 64'd0);
      chk("rst_wait", 64'(amm.waitrequest), 64'd1);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      idle(2);

      // RX burst of 4
      bus(1, 2, 64'h0401);
      src_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         src_data_i = 64'hA0 + 64'(i);
         cycle(a);
      end
      src_valid_i = 1'b0;
      chk("rx_req_early", 64'(request_o), 64'd0);
      cycle(a);
      chk("rx_req_rise", 64'(request_o), 64'd1);
      acknowledge_i = 1'b1;
      cycle(a);
      acknowledge_i = 1'b0;
      chk("rx_req_fall", 64'(request_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
         bus(0, 0, '0);
         chk("rx_rvalid", 64'(amm.readdatavalid), 64'd1);
         chk("rx_data", amm.readdata, 64'hA0 + 64'(i));
      end
      idle(4);
      chk("rx_no_rereq", 64'(request_o), 64'd0);
      bus(0, 1, '0);
      chk("rx_status", amm.readdata, 64'd0);

      // TX burst of 16 into a stalled consumer
      bus(1, 2, 64'h1003);
      cycle(a);
      chk("tx_req_rise", 64'(request_o), 64'd1);
      acknowledge_i = 1'b1;
      cycle(a);
      acknowledge_i = 1'b0;
      for (int i = 0; i < 16; i++) bus(1, 0, 64'h7000 + 64'(i));
      amm.address   = '0;
      amm.write     = 1'b1;
      amm.writedata = 64'h17;
      for (int i = 0; i < 3; i++) begin
         cycle(a);
         chk("tx_full_stall", 64'(a), 64'd0);
         chk("tx_full_wait", 64'(amm.waitrequest), 64'd1);
      end
      snk_ready_i = 1'b1;
      cycle(a);
      snk_ready_i = 1'b0;
      cycle(a);
      chk("tx_17th_accept", 64'(a), 64'd1);
      amm.write = 1'b0;
      snk_ready_i = 1'b1;
      idle(20);
      snk_ready_i = 1'b0;
      bus(1, 2, '0);
      idle(2);

      // Read stall on empty RX
      amm.address = '0;
      amm.read    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(a);
         chk("empty_stall", 64'(amm.waitrequest), 64'd1);
      end
      src_valid_i = 1'b1;
      src_data_i  = 64'h55;
      cycle(a);
      src_valid_i = 1'b0;
      cycle(a);
      amm.read = 1'b0;
      chk("empty_accept", 64'(a), 64'd1);
      chk("empty_data", amm.readdata, 64'h55);

      // Enable drop in REQ, then in XFER
      bus(1, 2, 64'h0203);
      cycle(a);
      chk("en_req_rise", 64'(request_o), 64'd1);
      bus(1, 2, 64'h0202);
      cycle(a);
      chk("en_req_drop", 64'(request_o), 64'd0);
      bus(1, 2, 64'h0303);
      cycle(a);
      acknowledge_i = 1'b1;
      cycle(a);
      acknowledge_i = 1'b0;
      bus(1, 0, 64'hB0);
      bus(1, 2, 64'h0302);
      bus(1, 0, 64'hB1);
      bus(0, 1, '0);
      chk("en_mid_busy", 64'(amm.readdata[16]), 64'd1);
      bus(1, 0, 64'hB2);
      bus(0, 1, '0);
      chk("en_mid_done", amm.readdata, 64'h300);
      snk_ready_i = 1'b1;
      idle(4);
      snk_ready_i = 1'b0;

      // Push and pop together at full
      src_valid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         src_data_i = 64'hC0 + 64'(i);
         cycle(a);
      end
      src_valid_i = 1'b0;
      bus(0, 1, '0);
      chk("full_level", amm.readdata, 64'h10);
      amm.address = '0;
      amm.read    = 1'b1;
      src_valid_i = 1'b1;
      src_data_i  = 64'hD0;
      cycle(a);
      amm.read    = 1'b0;
      src_valid_i = 1'b0;
      chk("full_pop", amm.readdata, 64'hC0);
      bus(0, 1, '0);
      chk("full_pushpop_level", amm.readdata, 64'h10);

      // Reset in the middle of an RX burst with a read response pending
      bus(1, 2, 64'h0401);
      cycle(a);
      chk("rst_req_rise", 64'(request_o), 64'd1);
      acknowledge_i = 1'b1;
      cycle(a);
      acknowledge_i = 1'b0;
      bus(0, 0, '0);
      amm.address = '0;
      amm.read    = 1'b1;
      #2;
      chk("pre_rst_rvalid", 64'(amm.readdatavalid), 64'd1);
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_rvalid", 64'(amm.readdatavalid), 64'd0);
      chk("mid_rst_request", 64'(request_o), 64'd0);
      chk("mid_rst_wait", 64'(amm.waitrequest), 64'd1);
      idle_in();
      model_reset();
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      idle(2);
      bus(0, 2, '0);
      chk("post_rst_ctrl", amm.readdata, 64'd0);
      bus(0, 1, '0);
      chk("post_rst_status", amm.readdata, 64'd0);

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) rnd_cycle();
      idle_in();
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
